// File: rtl/program_loader_pkg.sv
// Shared loader definitions: FSM state encoding and default geometry.
package program_loader_pkg;

  localparam int DEFAULT_ADDRESS_SIZE     = 10;
  localparam int DEFAULT_INSTRUCTION_SIZE = 16;
  localparam int LOADER_STATE_SIZE        = 3;

  typedef enum logic [LOADER_STATE_SIZE-1:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA    = 3'd3,
    RELEASE = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } loader_state_t;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs host bytes big-endian into one instruction word; word_complete flags
// the cycle in which the last byte of a word is being shifted in.
module program_loader_byte_assembler
  import program_loader_pkg::*;
#(
  parameter int INSTRUCTION_SIZE = DEFAULT_INSTRUCTION_SIZE
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        shift_en,
  input  logic [7:0]                  byte_in,
  output logic [INSTRUCTION_SIZE-1:0] word,
  output logic                        word_complete
);

  localparam int BYTES_PER_WORD = INSTRUCTION_SIZE / 8;
  localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  generate
    if (BYTES_PER_WORD == 1) begin : g_single
      assign word          = byte_in;
      assign word_complete = shift_en;
    end else begin : g_multi
      logic [INSTRUCTION_SIZE-9:0] sreg;
      logic [INSTRUCTION_SIZE-1:0] cat;
      logic [CW-1:0]               cnt;

      // The completed word is presented combinationally so the top can
      // register it on the same edge that accepts the final byte.
      assign cat           = {sreg, byte_in};
      assign word          = cat;
      assign word_complete = shift_en && (cnt == CW'(BYTES_PER_WORD - 1));

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sreg <= '0;
          cnt  <= '0;
        end else if (clear) begin
          sreg <= '0;
          cnt  <= '0;
        end else if (shift_en) begin
          sreg <= cat[INSTRUCTION_SIZE-9:0];
          cnt  <= word_complete ? '0 : cnt + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/program_loader.sv
// Core bring-up sequencer: holds the core in reset, streams a length-prefixed
// program image from the host byte link into program memory, then releases it.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDRESS_SIZE     = DEFAULT_ADDRESS_SIZE,
  parameter int INSTRUCTION_SIZE = DEFAULT_INSTRUCTION_SIZE
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        byte_ready,
  output logic                        prog_write,
  output logic [ADDRESS_SIZE-1:0]     prog_address,
  output logic [INSTRUCTION_SIZE-1:0] prog_data,
  output logic                        core_reset,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int WCW = ADDRESS_SIZE + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDRESS_SIZE;

  loader_state_t               state;
  logic [7:0]                  len_hi;
  logic [WCW-1:0]              len;
  logic [WCW-1:0]              word_cnt;
  logic [15:0]                 count16;
  logic                        xfer;
  logic                        shift_en;
  logic [INSTRUCTION_SIZE-1:0] word;
  logic                        word_complete;

  assign byte_ready = !start && (state == LEN_HI || state == LEN_LO || state == DATA);
  assign xfer       = byte_valid && byte_ready;
  assign shift_en   = xfer && (state == DATA);
  assign count16    = {len_hi, byte_data};

  program_loader_byte_assembler #(
    .INSTRUCTION_SIZE(INSTRUCTION_SIZE)
  ) u_asm (
    .clock        (clock),
    .reset        (reset),
    .clear        (start),
    .shift_en     (shift_en),
    .byte_in      (byte_data),
    .word         (word),
    .word_complete(word_complete)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      core_reset   <= 1'b0;
      prog_write   <= 1'b0;
      prog_address <= '0;
      prog_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      len_hi       <= '0;
      len          <= '0;
      word_cnt     <= '0;
    end else begin
      prog_write <= 1'b0;
      if (start) begin
        // Restart from anywhere; a partial word in the assembler is dropped.
        state      <= LEN_HI;
        word_cnt   <= '0;
        core_reset <= 1'b0;
        busy       <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
      end else begin
        case (state)
          LEN_HI: if (xfer) begin
            len_hi <= byte_data;
            state  <= LEN_LO;
          end
          LEN_LO: if (xfer) begin
            if (count16 == 16'd0) begin
              state      <= RUN;
              busy       <= 1'b0;
              done       <= 1'b1;
              core_reset <= 1'b1;
            end else if ({1'b0, count16} > MAX_WORDS) begin
              state <= ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              len   <= count16[ADDRESS_SIZE:0];
              state <= DATA;
            end
          end
          DATA: if (word_complete) begin
            prog_write   <= 1'b1;
            prog_address <= word_cnt[ADDRESS_SIZE-1:0];
            prog_data    <= word;
            word_cnt     <= word_cnt + WCW'(1);
            if (word_cnt == len - WCW'(1)) state <= RELEASE;
          end
          // Core leaves reset only after the final write has been strobed.
          RELEASE: begin
            state      <= RUN;
            busy       <= 1'b0;
            done       <= 1'b1;
            core_reset <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: directed header cases plus randomly gapped image loads
// scored against an expected write list built from the byte stream.
module tb_program_loader;

  localparam int AS = 10;
  localparam int IS = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready, prog_write, core_reset, busy, done, error;
  logic [AS-1:0] prog_address;
  logic [IS-1:0] prog_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  int rise_cyc = -1;
  int bad_wr = 0;
  logic prev_cr = 1'b0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  program_loader #(.ADDRESS_SIZE(AS), .INSTRUCTION_SIZE(IS)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .prog_write  (prog_write),
    .prog_address(prog_address),
    .prog_data   (prog_data),
    .core_reset  (core_reset),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (prog_write) begin
      obs_q.push_back(32'({prog_address, prog_data}));
      last_wr_cyc = cyc;
      if (core_reset) bad_wr++;
    end
    if (core_reset && !prev_cr) rise_cyc = cyc;
    prev_cr = core_reset;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int addr, input logic [15:0] data);
    return 32'({AS'(addr), data});
  endfunction

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic do_start(input logic bv, input logic [7:0] bd);
    start = 1'b1; byte_valid = bv; byte_data = bd;
    @(negedge clock);
    chk("ready_during_start", 32'(byte_ready), 32'd0);
    @(posedge clock); #1;
    start = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1; byte_data = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (byte_ready) begin
        @(posedge clock); #1;
        byte_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    chk("byte_timeout", 32'd0, 32'd1);
    byte_valid = 1'b0;
  endtask

  // Reference: n big-endian words streamed after a big-endian count header;
  // word i is expected at address i.
  task automatic load_image(input int n, input int max_gap);
    logic [15:0] w;
    send_byte(8'(n >> 8), max_gap);
    send_byte(8'(n), max_gap);
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      exp_q.push_back(mk(i, w));
      send_byte(w[15:8], max_gap);
      send_byte(w[7:0], max_gap);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [31:0] e, o;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk(tag, o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Call right after the edge accepting the last byte of an image.
  task automatic check_release(input string tag);
    @(negedge clock);
    chk({tag, "_last_wr"}, 32'(prog_write), 32'd1);
    chk({tag, "_cr_held"}, 32'(core_reset), 32'd0);
    @(negedge clock); #1;
    chk({tag, "_cr_up"}, 32'(core_reset), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rise"}, 32'(rise_cyc), 32'(last_wr_cyc + 1));
  endtask

  initial begin
    // Reset and idle
    #12 reset = 1'b1;
    repeat (5) tick();
    @(negedge clock);
    chk("idle_core_reset", 32'(core_reset), 32'd0);
    chk("idle_ready", 32'(byte_ready), 32'd0);
    chk("idle_write", 32'(prog_write), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_error", 32'(error), 32'd0);

    // Two-word image, byte_valid held
    do_start(1'b0, 8'h00);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    exp_q.push_back(mk(0, 16'h1234));
    exp_q.push_back(mk(1, 16'hABCD));
    check_release("two_word");
    check_writes("two_word_wr");

    // Zero-length header
    do_start(1'b0, 8'h00);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clock);
    chk("zero_cr", 32'(core_reset), 32'd1);
    chk("zero_done", 32'(done), 32'd1);
    check_writes("zero_wr");

    // Oversized header 1025
    do_start(1'b0, 8'h00);
    send_byte(8'h04, 0); send_byte(8'h01, 0);
    @(negedge clock);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_cr", 32'(core_reset), 32'd0);
    chk("ovf_done", 32'(done), 32'd0);
    byte_valid = 1'b1; #1;
    chk("ovf_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    @(posedge clock); #1;
    do_start(1'b0, 8'h00);
    @(negedge clock);
    chk("ovf_clear_error", 32'(error), 32'd0);
    chk("ovf_restart_busy", 32'(busy), 32'd1);
    chk("ovf_restart_ready", 32'(byte_ready), 32'd1);
    @(posedge clock); #1;

    // Mid-DATA abort, start-cycle byte must be refused
    do_start(1'b0, 8'h00);
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    exp_q.push_back(mk(0, 16'h1122));
    do_start(1'b1, 8'h77);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    exp_q.push_back(mk(0, 16'h5566));
    check_release("abort");
    check_writes("abort_wr");

    // Reload from RUN: full 1024-word image with random gaps
    chk("run_cr", 32'(core_reset), 32'd1);
    bad_wr = 0;
    do_start(1'b0, 8'h00);
    @(negedge clock);
    chk("reload_cr_fall", 32'(core_reset), 32'd0);
    chk("reload_busy", 32'(busy), 32'd1);
    @(posedge clock); #1;
    load_image(1024, 2);
    check_release("full");
    chk("full_no_wr_while_running", 32'(bad_wr), 32'd0);
    check_writes("full_wr");

    // A few short random reloads
    for (int k = 0; k < 4; k++) begin
      do_start(1'b0, 8'h00);
      load_image(int'($urandom_range(8, 1)), 3);
      check_release("rand");
      check_writes("rand_wr");
    end

    // Asynchronous reset mid-load
    do_start(1'b0, 8'h00);
    send_byte(8'h00, 0); send_byte(8'h05, 0); send_byte(8'h12, 0);
    @(negedge clock); #2;
    reset = 1'b0; #1;
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_cr", 32'(core_reset), 32'd0);
    chk("areset_ready", 32'(byte_ready), 32'd0);
    chk("areset_addr", 32'(prog_address), 32'd0);
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
